// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter onto one single-port RAM: bounded bursts, in-order read return routing.
// Define RAM_ARB_ROUND_ROBIN_EN to make simultaneous requests from IDLE alternate between requesters.
module ram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH    = 5,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned READ_LANTENCY = 3,
   parameter int unsigned BURST_LEN     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_we0,
   input  logic                  i_we1,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_din0,
   input  logic [DATA_WIDTH-1:0] i_din1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_rvalid0,
   output logic                  o_rvalid1,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_ram_en,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_din,
   input  logic [DATA_WIDTH-1:0] i_ram_dout
);
   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
   localparam int unsigned LAST  = READ_LANTENCY - 1;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    burst_done;
   logic                    pick0;
   logic                    ram_en_q;
   logic                    ram_we_q;
   logic                    ram_id_q;
   logic [ADDR_WIDTH-1:0]   ram_addr_q;
   logic [DATA_WIDTH-1:0]   ram_din_q;
   logic [READ_LANTENCY-1:0] pv_q;
   logic [READ_LANTENCY-1:0] pid_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   assign o_gnt0     = (state_q == OWN0) & i_req0;
   assign o_gnt1     = (state_q == OWN1) & i_req1;
   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign burst_done = (cnt_inc == CNT_W'(BURST_LEN));

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_q;

   // Remembers who made the most recent transfer; starts at 1 so requester 0 wins first.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         last_q <= 1'b1;
      end else if (o_gnt0) begin
         last_q <= 1'b0;
      end else if (o_gnt1) begin
         last_q <= 1'b1;
      end
   end

   assign pick0 = i_req0 & (~i_req1 | last_q);
`else
   assign pick0 = i_req0;
`endif

   // Ownership FSM; the counter only advances on transfers and clears on every hand-over.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (pick0) begin
                  state_q <= OWN0;
               end else if (i_req1) begin
                  state_q <= OWN1;
               end
            end
            OWN0: begin
               if (!i_req0) begin
                  cnt_q   <= '0;
                  state_q <= i_req1 ? OWN1 : IDLE;
               end else if (burst_done) begin
                  cnt_q <= '0;
                  if (i_req1) begin
                     state_q <= OWN1;
                  end
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            OWN1: begin
               if (!i_req1) begin
                  cnt_q   <= '0;
                  state_q <= i_req0 ? OWN0 : IDLE;
               end else if (burst_done) begin
                  cnt_q <= '0;
                  if (i_req0) begin
                     state_q <= OWN0;
                  end
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // RAM command register: one command per transfer edge, issued the following cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ram_en_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_id_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         ram_en_q <= o_gnt0 | o_gnt1;
         ram_we_q <= (o_gnt0 & i_we0) | (o_gnt1 & i_we1);
         ram_id_q <= o_gnt1;
         if (o_gnt1) begin
            ram_addr_q <= i_addr1;
            ram_din_q  <= i_din1;
         end else if (o_gnt0) begin
            ram_addr_q <= i_addr0;
            ram_din_q  <= i_din0;
         end
      end
   end

   // Read tracker: (valid, id) follows each issued read so returns route to their owner in order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pv_q    <= '0;
         pid_q   <= '0;
         rdata_q <= '0;
      end else begin
         pv_q[0]  <= ram_en_q & ~ram_we_q;
         pid_q[0] <= ram_id_q;
         for (int i = 1; i < READ_LANTENCY; i++) begin
            pv_q[i]  <= pv_q[i-1];
            pid_q[i] <= pid_q[i-1];
         end
         if (pv_q[LAST]) begin
            rdata_q <= i_ram_dout;
         end
      end
   end

   assign o_ram_en   = ram_en_q;
   assign o_ram_we   = ram_we_q;
   assign o_ram_addr = ram_addr_q;
   assign o_ram_din  = ram_din_q;
   assign o_rvalid0  = pv_q[LAST] & ~pid_q[LAST];
   assign o_rvalid1  = pv_q[LAST] & pid_q[LAST];
   // RAM data is only valid in the return cycle, so pass it through then and hold it afterwards.
   assign o_rdata    = pv_q[LAST] ? i_ram_dout : rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a latency-3 RAM model and a read-return scoreboard.
// Honours RAM_ARB_ROUND_ROBIN_EN for the IDLE arbitration expectation.
module tb_ram_port_arbiter;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned L     = 3;
   localparam int unsigned BL    = 4;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam logic [1:0] SECOND_WIN = 2'b01;
`else
   localparam logic [1:0] SECOND_WIN = 2'b10;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] din0, din1;
   logic          gnt0, gnt1, rv0, rv1;
   logic [DW-1:0] rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LANTENCY(L), .BURST_LEN(BL)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
      .i_addr0(addr0), .i_addr1(addr1), .i_din0(din0), .i_din1(din1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
      .o_rdata(rdata), .o_ram_en(ram_en), .o_ram_we(ram_we),
      .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(32'hA500_0000 + a);
   endfunction

   // RAM model: dout valid L cycles after the enable cycle, junk otherwise.
   logic [DW-1:0] mem [DEPTH];
   logic [L-1:0]  rv_pipe = '0;
   logic [DW-1:0] rd_pipe [L];
   always @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < int'(DEPTH); a++) mem[a] <= init_val(a);
      end else if (ram_en && ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      rv_pipe[0] <= ram_en && !ram_we;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < int'(L); i++) begin
         rv_pipe[i] <= rv_pipe[i-1];
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign ram_dout = rv_pipe[L-1] ? rd_pipe[L-1] : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      assert (got === want)
      else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   rd_t           rd_q[$];
   rd_t           pop_e;
   int            cyc = 0;
   logic [DW-1:0] shadow [DEPTH];
   logic          mon_id;
   logic          exp_en = 1'b0, exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din = '0, tb_rdata = '0;

   // Transfer monitor: predicts the next-cycle RAM command and queues expected read returns.
   always @(posedge clk) begin
      cyc++;
      exp_en = 1'b0;
      exp_we = 1'b0;
      if (rst) begin
         rd_q.delete();
         tb_rdata = '0;
         for (int a = 0; a < int'(DEPTH); a++) shadow[a] = init_val(a);
      end else if (gnt0 || gnt1) begin
         mon_id   = gnt1;
         exp_en   = 1'b1;
         exp_we   = mon_id ? we1 : we0;
         exp_addr = mon_id ? addr1 : addr0;
         exp_din  = mon_id ? din1 : din0;
         if (exp_we) shadow[exp_addr] = exp_din;
         else rd_q.push_back('{id: mon_id, data: shadow[exp_addr], due: cyc + int'(L)});
      end
   end

   // Per-cycle checker on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("gnt_excl", 64'(gnt0 & gnt1), 64'(0));
         chk("ram_en", 64'(ram_en), 64'(exp_en));
         chk("ram_we", 64'(ram_we), 64'(exp_we));
         if (exp_en) begin
            chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
            chk("ram_din", 64'(ram_din), 64'(exp_din));
         end
         if (rv0 || rv1) begin
            if (rd_q.size() == 0) begin
               chk("rv_unexpected", 64'({rv0, rv1}), 64'(0));
            end else begin
               pop_e = rd_q.pop_front();
               chk("rv_id", 64'({rv0, rv1}), pop_e.id ? 64'd1 : 64'd2);
               chk("rv_data", 64'(rdata), 64'(pop_e.data));
               chk("rv_cycle", 64'(cyc), 64'(pop_e.due));
               tb_rdata = pop_e.data;
            end
         end else begin
            chk("rdata_hold", 64'(rdata), 64'(tb_rdata));
            if (rd_q.size() != 0) chk("rv_missing", 64'(cyc > rd_q[0].due), 64'(0));
         end
      end
   end

   task automatic idle_all();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_en"}, 64'(ram_en), 64'(0));
      chk({tag, "_we"}, 64'(ram_we), 64'(0));
      chk({tag, "_addr"}, 64'(ram_addr), 64'(0));
      chk({tag, "_din"}, 64'(ram_din), 64'(0));
      chk({tag, "_rv"}, 64'({rv0, rv1}), 64'(0));
      chk({tag, "_rdata"}, 64'(rdata), 64'(0));
      chk({tag, "_gnt"}, 64'({gnt0, gnt1}), 64'(0));
   endtask

   // Drive one request and complete its transfer; waited = cycles until grant seen.
   task automatic xfer(input logic id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waited);
      logic got;
      got = 1'b0;
      waited = 0;
      if (id) begin req1 = 1'b1; we1 = we; addr1 = a; din1 = d; end
      else    begin req0 = 1'b1; we0 = we; addr0 = a; din0 = d; end
      while (!got && waited < 20) begin
         @(negedge clk);
         waited++;
         got = id ? gnt1 : gnt0;
      end
      chk("gnt_wait", 64'(got), 64'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_any_gnt(input string tag);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = gnt0 | gnt1;
      end
      chk({tag, "_seen"}, 64'(got), 64'(1));
   endtask

   task automatic wait_rv(input logic id, input logic [DW-1:0] d, input string tag);
      logic found;
      int   n;
      found = 1'b0;
      n = 0;
      while (!found && n < 16) begin
         @(negedge clk);
         n++;
         found = (id ? rv1 : rv0) && (rdata === d);
      end
      chk(tag, 64'(found), 64'(1));
   endtask

   logic [AW-1:0] sw_seq [4];
   int w;

   initial begin
      rst = 1'b1;
      idle_all();
      addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
      sw_seq[0] = AW'(0); sw_seq[1] = AW'(1); sw_seq[2] = AW'(3); sw_seq[3] = AW'(2);

      repeat (2) @(negedge clk);
      chk_reset("por");
      @(posedge clk);
      #1 rst = 1'b0;

      // Single write then read by requester 0
      xfer(1'b0, 1'b1, AW'(1), 32'h12, w);
      xfer(1'b0, 1'b0, AW'(1), 32'h0, w);
      chk("single_b2b", 64'(w), 64'(1));
      idle_all();
      wait_rv(1'b0, 32'h12, "single_rdata");
      repeat (4) @(negedge clk);
      chk("single_drain", 64'(rd_q.size()), 64'(0));

      // Lone requester 1: ten back-to-back grants across burst-limit boundaries
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         xfer(1'b1, 1'b0, AW'(i + 4), DW'(0), w);
         if (i > 0) chk("lone_b2b", 64'(w), 64'(1));
      end
      idle_all();
      @(negedge clk);
      chk("lone_drop", 64'({gnt0, gnt1}), 64'(0));

      // Contention: both held, grants alternate in bursts of BL
      @(posedge clk);
      #1;
      req0 = 1'b1; req1 = 1'b1; addr0 = AW'(0); addr1 = AW'(16);
      @(negedge clk);
      chk("ctn_idle", 64'({gnt0, gnt1}), 64'(0));
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("ctn_gnt", 64'({gnt0, gnt1}), ((i % (2 * BL)) < BL) ? 64'd2 : 64'd1);
         @(posedge clk);
         #1;
         addr0 = AW'(i + 1);
         addr1 = AW'(i + 17);
      end
      idle_all();
      repeat (8) @(negedge clk);
      chk("ctn_drain", 64'(rd_q.size()), 64'(0));

      // Reset one cycle before a read returns
      @(posedge clk);
      #1;
      xfer(1'b0, 1'b0, AW'(3), DW'(0), w);
      idle_all();
      repeat (L - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk_reset("rst_mid");
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rst_no_rv", 64'({rv0, rv1}), 64'(0));
      end

      // Simultaneous requests from IDLE twice with an idle gap
      @(posedge clk);
      #1;
      req0 = 1'b1; req1 = 1'b1; addr0 = AW'(4); addr1 = AW'(6);
      wait_any_gnt("rr1");
      chk("rr_first", 64'({gnt0, gnt1}), 64'(2'b10));
      @(posedge clk);
      #1 idle_all();
      repeat (4) @(posedge clk);
      #1;
      req0 = 1'b1; req1 = 1'b1;
      wait_any_gnt("rr2");
      chk("rr_second", 64'({gnt0, gnt1}), 64'(SECOND_WIN));
      @(posedge clk);
      #1 idle_all();
      repeat (6) @(posedge clk);
      #1;

      // Burst-limit switch with reads in flight: A from 0 then B from 1 on consecutive cycles
      req0 = 1'b1; req1 = 1'b1; addr0 = sw_seq[0]; addr1 = AW'(5);
      wait_any_gnt("sw");
      chk("sw_first", 64'({gnt0, gnt1}), 64'(2'b10));
      for (int j = 0; j < 4; j++) begin
         if (j > 0) begin
            @(negedge clk);
            chk("sw_burst0", 64'({gnt0, gnt1}), 64'(2'b10));
         end
         @(posedge clk);
         #1;
         if (j < 3) addr0 = sw_seq[j + 1];
         else req0 = 1'b0;
      end
      @(negedge clk);
      chk("sw_to1", 64'({gnt0, gnt1}), 64'(2'b01));
      @(posedge clk);
      #1 idle_all();
      wait_rv(1'b0, init_val(2), "sw_A");
      @(negedge clk);
      chk("sw_B_rv", 64'({rv0, rv1}), 64'(2'b01));
      chk("sw_B_data", 64'(rdata), 64'(init_val(5)));

      repeat (8) @(negedge clk);
      chk("final_drain", 64'(rd_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_WIDTH, 5, RAM address bits; DATA_WIDTH, 32, RAM data bits; READ_LANTENCY, 3, RAM cycles from en to valid dout; BURST_LEN, 4, max consecutive grants to one requester.
REQ-002 SHALL have ports (name direction width meaning), one clock, reset asynchronous active-high:
i_clk  in  1  sole clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_req0 / i_req1  in  1  requester access request
i_we0 / i_we1  in  1  1=write, 0=read
i_addr0 / i_addr1  in  ADDR_WIDTH  access address
i_din0 / i_din1  in  DATA_WIDTH  write data
o_gnt0 / o_gnt1  out  1  combinational grant; transfer occurs when req & gnt at rising edge
o_rvalid0 / o_rvalid1  out  1  read data valid pulse
o_rdata  out  DATA_WIDTH  read data, shared
o_ram_en  out  1  RAM port enable
o_ram_we  out  1  RAM port write enable
o_ram_addr  out  ADDR_WIDTH  RAM address
o_ram_din  out  DATA_WIDTH  RAM write data
i_ram_dout  in  DATA_WIDTH  RAM read data

Function
REQ-003 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-004 o_gnt0 SHALL be 1 only in OWN0 with i_req0=1; o_gnt1 only in OWN1 with i_req1=1; never both.
REQ-005 IDLE -> OWN0 if i_req0, else OWN1 if i_req1 (priority per REQ-016/017); IDLE grants nothing.
REQ-006 In OWNx, each edge with req&gnt SHALL be one transfer and SHALL increment a burst counter (width ceil(log2(BURST_LEN+1))).
REQ-007 OWNx SHALL switch to OWNy when i_reqx=0 and i_reqy=1, or when the counter reaches BURST_LEN and i_reqy=1; counter clears on every switch.
REQ-008 OWNx SHALL go to IDLE when neither request is asserted; at BURST_LEN with only x requesting, it SHALL stay in OWNx and clear the counter.
REQ-009 A transfer at edge N SHALL drive o_ram_en=1, o_ram_we, o_ram_addr, o_ram_din (registered from the granted requester) during cycle N+1; o_ram_en=0 and o_ram_we=0 otherwise.
REQ-010 Back-to-back transfers SHALL issue one RAM command per cycle with no bubbles, including across owner switches.
REQ-011 A read issued in cycle N+1 SHALL assert o_rvalidx for exactly one cycle, N+1+READ_LANTENCY, with o_rdata = i_ram_dout in that cycle; tracked by a READ_LANTENCY-deep shift register of (valid, id).
REQ-012 Read returns SHALL be in issue order; a switch SHALL NOT drop or misroute in-flight reads.
REQ-013 Writes SHALL produce no o_rvalid pulse.
REQ-014 o_rdata SHALL hold its last value when no o_rvalid is asserted.

Reset
REQ-015 On i_rst=1 (asynchronous) state=IDLE, counter=0, read pipeline cleared, o_ram_en=0, o_ram_we=0, o_ram_addr=0, o_ram_din=0, o_rvalid0/1=0, o_rdata=0; in-flight reads SHALL be discarded with no o_rvalid after release; first grant possible in the first cycle after deassertion.

Configuration
REQ-016 With macro RAM_ARB_ROUND_ROBIN_EN defined, a last-owner bit SHALL choose from IDLE the requester not served last when both request; last-owner resets to 1 (requester 0 wins first).
REQ-017 Without RAM_ARB_ROUND_ROBIN_EN, requester 0 SHALL win from IDLE on simultaneous requests; REQ-007 burst limit still applies.

Verification
REQ-018 Reset mid-read: read at addr 3 issued, i_rst high 1 cycle before return -> no o_rvalid0, all outputs at reset values.
REQ-019 Single: req0 write addr 1 data 32'h12, then read addr 1 -> o_ram_en/we 1 cycle after grant edge; o_rvalid0 READ_LANTENCY (3) cycles after read en, o_rdata=32'h12.
REQ-020 Contention: req0 and req1 held high continuously, BURST_LEN=4 -> grants 0,0,0,0,1,1,1,1,0... with no idle RAM cycles.
REQ-021 Switch with in-flight reads: req0 reads addr 2 (data A), req1 reads addr 5 (data B) next cycle -> o_rvalid0 with A then o_rvalid1 with B on consecutive cycles.
REQ-022 Both request from IDLE twice with idle gap: macro defined -> 0 then 1 granted first; undefined -> 0 both times.
REQ-023 Lone requester: req1 held 10 cycles -> 10 consecutive grants, state stays OWN1, then IDLE after req1 drops.
